sdram_dma_engine: RTL and testbench

//  Parametrised Avalon-MM bus master that moves num_words words from src_addr to dest_addr, or fills

---
 rtl/sdram_dma_engine_if.sv | 23 ++
 rtl/sdram_dma_engine.sv | 197 +++++++++++++++++++
 tb/tb_sdram_dma_engine.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_dma_engine_if.sv
// Avalon-MM master bus bundle between the DMA engine and the SDRAM controller port.
interface sdram_dma_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              master_waitrequest;
    logic [ADDR_W-1:0] master_address;
    logic              master_read;
    logic [DATA_W-1:0] master_readdata;
    logic              master_readdatavalid;
    logic              master_write;
    logic [DATA_W-1:0] master_writedata;

    modport master (
        input  master_waitrequest, master_readdata, master_readdatavalid,
        output master_address, master_read, master_write, master_writedata
    );

    modport slave (
        output master_waitrequest, master_readdata, master_readdatavalid,
        input  master_address, master_read, master_write, master_writedata
    );
endinterface

// File: rtl/sdram_dma_engine.sv
// Pipelined Avalon-MM DMA master: copies num_words words from src to dest through a
// read-data FIFO (reads run ahead, bounded by FIFO credits), or fills dest with a constant.
module sdram_dma_engine #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dest_addr,
    input  logic [31:0]         num_words,
    input  logic                fill_mode,
    input  logic [DATA_W-1:0]   fill_value,
    input  logic                start,
    output logic                busy,
    output logic                done,
    sdram_dma_engine_if.master  bus
);
    localparam int BPW = DATA_W / 8;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
    logic [31:0]       num_q, num_d, rd_issued_q, rd_issued_d, wr_done_q, wr_done_d;
    logic              fill_q, fill_d;
    logic [DATA_W-1:0] fval_q, fval_d, wdata_q, wdata_d;
    logic [CW-1:0]     in_flight_q, in_flight_d, count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic              busy_q, busy_d, done_q, done_d, read_q, read_d, write_q, write_d;

    logic              rd_acc, wr_acc, push, pop, can_rd, can_wr;
    logic [CW-1:0]     after_pop;
    logic [DATA_W-1:0] head;

    // Next-state: counters, FIFO bookkeeping and the registered command for the following cycle.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        addr_d      = addr_q;
        num_d       = num_q;
        rd_issued_d = rd_issued_q;
        wr_done_d   = wr_done_q;
        fill_d      = fill_q;
        fval_d      = fval_q;
        wdata_d     = wdata_q;
        in_flight_d = in_flight_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        mem_d       = mem_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        read_d      = read_q;
        write_d     = write_q;

        rd_acc    = read_q & ~bus.master_waitrequest;
        wr_acc    = write_q & ~bus.master_waitrequest;
        push      = (state_q == RUN) & ~fill_q & bus.master_readdatavalid;
        pop       = wr_acc & ~fill_q;
        after_pop = '0;
        head      = '0;
        can_rd    = 1'b0;
        can_wr    = 1'b0;

        unique case (state_q)
            IDLE: begin
                read_d  = 1'b0;
                write_d = 1'b0;
                if (start) begin
                    src_d       = src_addr;
                    dst_d       = dest_addr;
                    num_d       = num_words;
                    fill_d      = fill_mode;
                    fval_d      = fill_value;
                    rd_issued_d = '0;
                    wr_done_d   = '0;
                    in_flight_d = '0;
                    count_d     = '0;
                    rd_ptr_d    = '0;
                    wr_ptr_d    = '0;
                    if (num_words == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (push) begin
                    mem_d[wr_ptr_q] = bus.master_readdata;
                    wr_ptr_d        = wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                count_d     = count_q + CW'(push) - CW'(pop);
                in_flight_d = in_flight_q + CW'(rd_acc) - CW'(push);
                if (rd_acc) rd_issued_d = rd_issued_q + 32'd1;
                if (wr_acc) wr_done_d = wr_done_q + 32'd1;

                // If the FIFO holds nothing once the pop is applied, the next head is the
                // word arriving this very cycle, which is not yet in the storage array.
                after_pop = count_q - CW'(pop);
                head      = (after_pop == '0) ? bus.master_readdata : mem_q[rd_ptr_d];
                can_wr    = fill_q ? (wr_done_d < num_q) : (count_d != '0);
                can_rd    = ~fill_q & (rd_issued_d < num_q) &
                            (({1'b0, in_flight_d} + {1'b0, count_d}) < DEPTH_C);

                if (wr_acc && (wr_done_d == num_q)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end else if (!((read_q | write_q) && bus.master_waitrequest)) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (can_wr) begin
                        write_d = 1'b1;
                        addr_d  = dst_q + ADDR_W'(wr_done_d) * ADDR_W'(BPW);
                        wdata_d = fill_q ? fval_q : head;
                    end else if (can_rd) begin
                        read_d = 1'b1;
                        addr_d = src_q + ADDR_W'(rd_issued_d) * ADDR_W'(BPW);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            addr_q      <= '0;
            num_q       <= '0;
            rd_issued_q <= '0;
            wr_done_q   <= '0;
            fill_q      <= 1'b0;
            fval_q      <= '0;
            wdata_q     <= '0;
            in_flight_q <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            mem_q       <= '{default: '0};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            addr_q      <= addr_d;
            num_q       <= num_d;
            rd_issued_q <= rd_issued_d;
            wr_done_q   <= wr_done_d;
            fill_q      <= fill_d;
            fval_q      <= fval_d;
            wdata_q     <= wdata_d;
            in_flight_q <= in_flight_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_q       <= mem_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            read_q      <= read_d;
            write_q     <= write_d;
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign bus.master_address   = addr_q;
    assign bus.master_read      = read_q;
    assign bus.master_write     = write_q;
    assign bus.master_writedata = wdata_q;
endmodule

// File: tb/tb_sdram_dma_engine.sv
// Directed bench for sdram_dma_engine: a table of transfers run against an in-order
// Avalon slave model, plus a hand-written mid-transfer reset sequence.
module tb_sdram_dma_engine;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int FIFO_DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] src_addr, dest_addr;
    logic [31:0]       num_words;
    logic              fill_mode;
    logic [DATA_W-1:0] fill_value;
    logic              start;
    logic              busy, done;

    sdram_dma_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

    sdram_dma_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .src_addr(src_addr), .dest_addr(dest_addr),
        .num_words(num_words), .fill_mode(fill_mode), .fill_value(fill_value),
        .start(start), .busy(busy), .done(done), .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] src, dst, num;
        logic        fill;
        logic [31:0] fval;
        int          wait_pct, lat_lo, lat_hi;
        int          want_rd, want_wr;
        logic [31:0] want_lr, want_lw, want_ld;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        rq[$];
    int          n_vec = 0, n_bad = 0;
    int          cyc = 0, last_due = 0;
    int          wait_pct = 0, lat_lo = 1, lat_hi = 1;
    logic [31:0] e_src, e_dst, e_fval;
    logic        e_fill;
    int          rd_idx, wr_idx, done_cnt, max_out, stable_err;
    logic [31:0] last_raddr, last_waddr, last_wdata;
    logic        prev_hold = 1'b0, prev_rd, prev_wr;
    logic [31:0] prev_addr, prev_data;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // One bus cycle at the falling edge: return responses, drive waitrequest, log accepts.
    task automatic bus_cycle();
        logic        wreq;
        int          lat, due, out;
        logic [31:0] ea, ed;
        rsp_t        r;
        @(negedge clk);
        cyc++;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            bus_if.master_readdatavalid = 1'b1;
            bus_if.master_readdata      = rq[0].data;
            void'(rq.pop_front());
        end else begin
            bus_if.master_readdatavalid = 1'b0;
            bus_if.master_readdata      = 32'h0BAD_F00D;
        end
        if (prev_hold && (bus_if.master_read !== prev_rd || bus_if.master_write !== prev_wr ||
                          bus_if.master_address !== prev_addr ||
                          (prev_wr && bus_if.master_writedata !== prev_data)))
            stable_err++;
        if (bus_if.master_read && bus_if.master_write) stable_err++;
        if (done) done_cnt++;
        wreq = (wait_pct > 0) && (int'($urandom_range(99)) < wait_pct);
        bus_if.master_waitrequest = wreq;
        if (bus_if.master_read && !wreq) begin
            ea = e_src + 32'(rd_idx) * 4;
            check("rd_addr", bus_if.master_address, ea);
            last_raddr = bus_if.master_address;
            rd_idx++;
            lat = int'($urandom_range(lat_hi, lat_lo));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.due  = due;
            r.data = mdata(bus_if.master_address);
            rq.push_back(r);
        end
        if (bus_if.master_write && !wreq) begin
            ea = e_dst + 32'(wr_idx) * 4;
            ed = e_fill ? e_fval : mdata(e_src + 32'(wr_idx) * 4);
            check("wr_addr", bus_if.master_address, ea);
            check("wr_data", bus_if.master_writedata, ed);
            last_waddr = bus_if.master_address;
            last_wdata = bus_if.master_writedata;
            wr_idx++;
        end
        out = rd_idx - wr_idx;
        if (out > max_out) max_out = out;
        prev_hold = (bus_if.master_read || bus_if.master_write) && wreq;
        prev_rd   = bus_if.master_read;
        prev_wr   = bus_if.master_write;
        prev_addr = bus_if.master_address;
        prev_data = bus_if.master_writedata;
    endtask

    task automatic setup(input vec_t v);
        e_src = v.src; e_dst = v.dst; e_fill = v.fill; e_fval = v.fval;
        src_addr = v.src; dest_addr = v.dst; num_words = v.num;
        fill_mode = v.fill; fill_value = v.fval;
        wait_pct = v.wait_pct; lat_lo = v.lat_lo; lat_hi = v.lat_hi;
        rd_idx = 0; wr_idx = 0; done_cnt = 0; max_out = 0; stable_err = 0; prev_hold = 1'b0;
    endtask

    task automatic run_vector(input vec_t v);
        setup(v);
        start = 1'b1;
        bus_cycle();
        start = 1'b0;
        check("done_next_cycle", done, v.num == 0);
        check("busy_after_start", busy, v.num != 0);
        for (int k = 0; k < 3000 && done_cnt == 0; k++) bus_cycle();
        check("busy_at_done", busy, 0);
        for (int k = 0; k < 4; k++) bus_cycle();
        check("done_pulses", done_cnt, 1);
        check("reads", rd_idx, v.want_rd);
        check("writes", wr_idx, v.want_wr);
        if (v.want_rd > 0) check("last_raddr", last_raddr, v.want_lr);
        if (v.want_wr > 0) begin
            check("last_waddr", last_waddr, v.want_lw);
            check("last_wdata", last_wdata, v.want_ld);
        end
        check("cmd_stable", stable_err, 0);
        check("credit_bound", max_out <= FIFO_DEPTH, 1);
    endtask

    vec_t vt[6];
    vec_t vr, vpost;
    int   rd_save;

    initial begin
        //        src           dst           num    fill  fval          w%  lat   rd  wr  last_raddr    last_waddr    last_wdata
        vt[0] = '{32'h0000_0100, 32'h0000_0200, 32'd4,  1'b0, 32'h0,          0, 1, 1,  4,  4, 32'h0000_010C, 32'h0000_020C, 32'hA5A5_010C};
        vt[1] = '{32'h0000_0100, 32'h0000_0200, 32'd0,  1'b0, 32'h0,          0, 1, 1,  0,  0, 32'h0,         32'h0,         32'h0};
        vt[2] = '{32'h0000_0000, 32'h0000_0040, 32'd3,  1'b1, 32'hDEAD_BEEF,  0, 1, 1,  0,  3, 32'h0,         32'h0000_0048, 32'hDEAD_BEEF};
        vt[3] = '{32'h0000_1000, 32'h0000_8000, 32'd32, 1'b0, 32'h0,         40, 1, 10, 32, 32, 32'h0000_107C, 32'h0000_807C, 32'hA5A5_107C};
        vt[4] = '{32'hFFFF_FFF8, 32'h0000_0300, 32'd4,  1'b0, 32'h0,          0, 1, 1,  4,  4, 32'h0000_0004, 32'h0000_030C, 32'hA5A5_0004};
        vt[5] = '{32'h0000_0000, 32'hFFFF_FFFC, 32'd2,  1'b1, 32'h1234_5678, 50, 1, 1,  0,  2, 32'h0,         32'h0000_0000, 32'h1234_5678};
        vr    = '{32'h0000_2000, 32'h0000_3000, 32'd16, 1'b0, 32'h0,          0, 3, 3,  0,  0, 32'h0,         32'h0,         32'h0};
        vpost = '{32'h0000_0500, 32'h0000_0600, 32'd2,  1'b0, 32'h0,          0, 2, 2,  2,  2, 32'h0000_0504, 32'h0000_0604, 32'hA5A5_0504};

        rst = 1'b1; start = 1'b0; src_addr = '0; dest_addr = '0; num_words = '0;
        fill_mode = 1'b0; fill_value = '0;
        bus_if.master_waitrequest = 1'b0; bus_if.master_readdatavalid = 1'b0;
        bus_if.master_readdata = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_read", bus_if.master_read, 0);
        check("reset_write", bus_if.master_write, 0);
        check("reset_addr", bus_if.master_address, 0);
        check("reset_wdata", bus_if.master_writedata, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vector(vt[i]);

        // Reset three writes into a copy; start is held and the inputs change meanwhile.
        setup(vr);
        start = 1'b1;
        bus_cycle();
        src_addr = 32'h0000_9000; dest_addr = 32'h0000_A000; fill_mode = 1'b1;
        for (int k = 0; k < 200 && wr_idx < 3; k++) bus_cycle();
        check("writes_before_rst", wr_idx, 3);
        check("stable_before_rst", stable_err, 0);
        wait_pct = 100;
        bus_cycle();
        rst = 1'b1; start = 1'b0;
        rd_save = rd_idx; prev_hold = 1'b0; done_cnt = 0;
        bus_cycle();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_read", bus_if.master_read, 0);
        check("rst_write", bus_if.master_write, 0);
        check("rst_addr", bus_if.master_address, 0);
        check("rst_wdata", bus_if.master_writedata, 0);
        rst = 1'b0; wait_pct = 0;
        for (int k = 0; k < 20; k++) bus_cycle();
        check("idle_reads_after_rst", rd_idx, rd_save);
        check("idle_writes_after_rst", wr_idx, 3);
        check("no_done_after_rst", done_cnt, 0);
        check("idle_busy_after_rst", busy, 0);

        // A fresh copy must not see words left over from the aborted one.
        run_vector(vpost);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
